// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
// One radix-2 iteration per clock: shift-add for multiply and restoring
// shift-subtract for divide. Operands are reduced to magnitudes on
// acceptance, and the result sign is re-applied on the final iteration.
// Optional build macro MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow complete straight from IDLE, without iterating.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            regwrite
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

   // Conditionally negate a magnitude (two's complement), single width.
   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag,
                                                  input logic neg);
      logic signed [XLEN-1:0] s;
      s = $signed(mag);
      return neg ? $unsigned(-s) : mag;
   endfunction

   // Conditionally negate a magnitude (two's complement), double width.
   function automatic logic [2*XLEN-1:0] apply_sign2(input logic [2*XLEN-1:0] mag,
                                                     input logic neg);
      logic signed [2*XLEN-1:0] s;
      s = $signed(mag);
      return neg ? $unsigned(-s) : mag;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [2:0]       op_q,    op_d;
   logic [4:0]       rd_q,    rd_d;
   logic [XLEN-1:0]  opd_q,   opd_d;   // multiplicand (mul) or divisor (div) magnitude
   logic [XLEN-1:0]  hi_q,    hi_d;    // product high half / partial remainder
   logic [XLEN-1:0]  lo_q,    lo_d;    // multiplier -> product low / dividend -> quotient
   logic             neg_q,   neg_d;   // result must be negated at the end
   logic [XLEN-1:0]  res_q,   res_d;
   logic [4:0]       rdo_q,   rdo_d;

   // Operand decode on the request side
   logic            in_div;
   logic            sgn_a_en, sgn_b_en;
   logic            sa, sb;
   logic            div0_in;
   logic            neg_in;
   logic [XLEN-1:0] a_abs, b_abs;

   // Decode signedness of the incoming op and form operand magnitudes
   always_comb begin
      in_div   = funct3[2];
      sgn_a_en = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                 (funct3 == OP_DIV)  || (funct3 == OP_REM);
      sgn_b_en = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
      sa       = sgn_a_en & rs1_data[XLEN-1];
      sb       = sgn_b_en & rs2_data[XLEN-1];
      div0_in  = (rs2_data == '0);
      a_abs    = apply_sign(rs1_data, sa);
      b_abs    = apply_sign(rs2_data, sb);
      case (funct3)
         OP_MULH:   neg_in = sa ^ sb;
         OP_MULHSU: neg_in = sa;
         // A zero divisor yields all-ones unsigned-style, never negated.
         OP_DIV:    neg_in = (sa ^ sb) & ~div0_in;
         // Remainder sign follows the dividend.
         OP_REM:    neg_in = sa;
         default:   neg_in = 1'b0;
      endcase
   end

`ifdef MULDIV_FAST_SPECIAL_EN
   logic            ovf_in;
   logic            fast_hit;
   logic [XLEN-1:0] fast_res;

   // Detect divide-by-zero / signed overflow and form their fixed results
   always_comb begin
      ovf_in   = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                 (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
      fast_hit = in_div && (div0_in || ovf_in);
      if (div0_in)
         fast_res = funct3[1] ? rs1_data : '1;
      else
         fast_res = funct3[1] ? '0 : rs1_data;
   end
`endif

   // One iteration of the datapath
   logic [XLEN:0]     mul_sum;
   logic [XLEN-1:0]   mul_hi_nx, mul_lo_nx;
   logic [XLEN:0]     div_sh, div_diff;
   logic              div_ok;
   logic [XLEN-1:0]   div_hi_nx, div_lo_nx;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mul_res, div_res, fin_res;

   // Shift-add multiply step, restoring divide step, and final sign fix-up
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
      mul_hi_nx = mul_sum[XLEN:1];
      mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};

      div_sh    = {hi_q, lo_q[XLEN-1]};
      div_ok    = (div_sh >= {1'b0, opd_q});
      div_diff  = div_sh - {1'b0, opd_q};
      div_hi_nx = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      div_lo_nx = {lo_q[XLEN-2:0], div_ok};

      prod      = apply_sign2({mul_hi_nx, mul_lo_nx}, neg_q);
      mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      div_res   = op_q[1] ? apply_sign(div_hi_nx, neg_q) : apply_sign(div_lo_nx, neg_q);
      fin_res   = op_q[2] ? div_res : mul_res;
   end

   // Control FSM and next-state of all registers
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rd_d    = rd_q;
      opd_d   = opd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      res_d   = res_q;
      rdo_d   = rdo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = funct3;
               rd_d    = rd_in;
               neg_d   = neg_in;
               cnt_d   = '0;
               hi_d    = '0;
               lo_d    = in_div ? a_abs : b_abs;
               opd_d   = in_div ? b_abs : a_abs;
               state_d = S_CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
               if (fast_hit) begin
                  res_d   = fast_res;
                  rdo_d   = rd_in;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            hi_d  = op_q[2] ? div_hi_nx : mul_hi_nx;
            lo_d  = op_q[2] ? div_lo_nx : mul_lo_nx;
            if (cnt_q == LAST_CNT) begin
               res_d   = fin_res;
               rdo_d   = rd_q;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, all cleared by asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         opd_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
         rdo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         opd_q   <= opd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         rdo_q   <= rdo_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign result   = res_q;
   assign rd_out   = rdo_q;
   assign regwrite = done && (rdo_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic        regwrite;

   int vectors     = 0;
   int miscompares = 0;

`ifdef MULDIV_FAST_SPECIAL_EN
   localparam int SPEC_EDGES = 0;
`else
   localparam int SPEC_EDGES = 32;
`endif

   muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_in    (rd_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .rd_out   (rd_out),
      .regwrite (regwrite)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one op; exp_edges = clock edges after the start edge until done is seen.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_edges, input bit disturb);
      int n;
      int busy_n;
      bit got;
      @(negedge clk);
      funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0; busy_n = 0; got = 0;
      if (busy) busy_n++;
      if (done) got = 1;
      while (!got && n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (disturb && n == 5) begin
            start = 1'b1; funct3 = 3'b000; rs1_data = 32'd100; rs2_data = 32'd100; rd_in = 5'd9;
         end
         if (disturb && n == 8) start = 1'b0;
         if (busy) busy_n++;
         if (done) got = 1;
      end
      check({tag, " latency"},  n, exp_edges);
      check({tag, " result"},   result, exp_res);
      check({tag, " rd_out"},   {27'd0, rd_out}, {27'd0, rd});
      check({tag, " regwrite"}, {31'd0, regwrite}, {31'd0, (rd != 5'd0)});
      check({tag, " busy_cyc"}, busy_n, exp_edges + 1);
      @(posedge clk);
      #1;
      check({tag, " done_end"}, {31'd0, done}, 32'd0);
      check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
      check({tag, " hold"},     result, exp_res);
   endtask

   initial begin
      int seen;
      rst = 1'b1; start = 1'b0; funct3 = 3'b000; rs1_data = '0; rs2_data = '0; rd_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy",     {31'd0, busy}, 32'd0);
      check("rst done",     {31'd0, done}, 32'd0);
      check("rst result",   result, 32'd0);
      check("rst rd_out",   {27'd0, rd_out}, 32'd0);
      check("rst regwrite", {31'd0, regwrite}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("mul7x6",    3'b000, 32'd7,        32'd6,        5'd5, 32'h0000002A, 32, 0);
      run_op("mulneg",    3'b000, 32'hFFFFFFFE, 32'd3,        5'd6, 32'hFFFFFFFA, 32, 0);
      run_op("mulh",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, 32, 0);
      run_op("mulhu",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFE, 32, 0);
      run_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd9, 32'hFFFFFFFF, 32, 0);
      run_op("div-7/2",   3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFD, 32, 0);
      run_op("rem-7/2",   3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFF, 32, 0);
      run_op("divu",      3'b101, 32'hFFFFFFF9, 32'h00000002, 5'd12, 32'h7FFFFFFC, 32, 0);
      run_op("div5/0",    3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, SPEC_EDGES, 0);
      run_op("remu5/0",   3'b111, 32'd5,        32'd0,        5'd14, 32'h00000005, SPEC_EDGES, 0);
      run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, SPEC_EDGES, 0);
      run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, SPEC_EDGES, 0);
      run_op("disturb",   3'b000, 32'd7,        32'd6,        5'd5, 32'h0000002A, 32, 1);
      run_op("rd0",       3'b111, 32'd10,       32'd3,        5'd0, 32'h00000001, 32, 0);

      // Reset in the middle of an operation: abandoned, outputs cleared at once.
      @(negedge clk);
      funct3 = 3'b000; rs1_data = 32'h1234; rs2_data = 32'd2; rd_in = 5'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst busy",     {31'd0, busy}, 32'd0);
      check("midrst done",     {31'd0, done}, 32'd0);
      check("midrst result",   result, 32'd0);
      check("midrst rd_out",   {27'd0, rd_out}, 32'd0);
      check("midrst regwrite", {31'd0, regwrite}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check("midrst no_done", seen, 0);

      run_op("mul3x3", 3'b000, 32'd3, 32'd3, 5'd1, 32'h00000009, 32, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
